// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Types and constants shared by the cache and its miss/refill controller.
//   missState_t   : miss-handler FSM states
//   BYTE_OFFSET   : number of byte-offset bits below the word address
//   CACHE_*_WIDTH : default data/address widths shared with the cache
// ----------------------------------------------------------------------------
package cache_pkg;

  localparam int unsigned CACHE_DATA_WIDTH = 32;
  localparam int unsigned CACHE_ADDR_WIDTH = 32;
  localparam int unsigned BYTE_OFFSET      = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    REFILL
  } missState_t;

endpackage

// File: rtl/cache_miss_handler.sv
// ----------------------------------------------------------------------------
// cache_miss_handler
// Miss/refill controller behind a two-way associative cache. Hits are passed
// straight through to the CPU; a miss stalls the CPU, fetches the word from
// memory (valid/ready request, response-valid return) and performs a single
// cycle refill write that also returns the word to the CPU.
//
// Ports
//   clk, rst                 : clock, async active-high reset
//   reqValid_i, addressWord_i: CPU load access and byte address
//   hit_i, cacheData_i       : cache lookup result
//   stall_o                  : freeze CPU pipeline
//   dataWord_o, dataValid_o  : load data returned to CPU
//   memReqValid_o/Ready_i    : memory read request handshake
//   memAddr_o                : word-aligned request address
//   memRespValid_i, memData_i: memory response
//   refillEn_o/Addr_o/Data_o : cache refill write
//   timeout_o                : pulse when a request is reissued
//   missCount_o              : saturating miss counter
// ----------------------------------------------------------------------------
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = CACHE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = CACHE_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid_i,
  input  logic [ADDR_WIDTH-1:0] addressWord_i,
  input  logic                  hit_i,
  input  logic [DATA_WIDTH-1:0] cacheData_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] dataWord_o,
  output logic                  dataValid_o,
  output logic                  memReqValid_o,
  input  logic                  memReqReady_i,
  output logic [ADDR_WIDTH-1:0] memAddr_o,
  input  logic                  memRespValid_i,
  input  logic [DATA_WIDTH-1:0] memData_i,
  output logic                  refillEn_o,
  output logic [ADDR_WIDTH-1:0] refillAddr_o,
  output logic [DATA_WIDTH-1:0] refillData_o,
  output logic                  timeout_o,
  output logic [CNT_WIDTH-1:0]  missCount_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  missState_t            r_state;
  missState_t            w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TW-1:0]         r_tcnt;
  logic [CNT_WIDTH-1:0]  r_missCnt;

  logic w_miss;
  logic w_handshake;
  logic w_resp;
  logic w_unused;

  assign w_miss      = (r_state == IDLE) && reqValid_i && !hit_i;
  assign w_handshake = (r_state == REQ) && memReqReady_i;
  assign w_resp      = (r_state == WAIT) && memRespValid_i;

  // Byte-offset bits never reach memory; requests are word aligned.
  assign w_unused = ^addressWord_i[BYTE_OFFSET-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Word-aligned miss address, captured in the miss cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_miss) begin
      r_addr <= {addressWord_i[ADDR_WIDTH-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}};
    end
  end

  // Response data, held for the refill cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_resp) begin
      r_data <= memData_i;
    end
  end

  // Timeout counter: cleared on request acceptance, counts WAIT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (w_handshake) begin
      r_tcnt <= '0;
    end else if (r_state == WAIT) begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // Saturating miss counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_missCnt <= '0;
    end else if (w_miss && (r_missCnt != '1)) begin
      r_missCnt <= r_missCnt + CNT_WIDTH'(1);
    end
  end

  assign missCount_o = r_missCnt;

  // Next-state and output decode
  always_comb begin
    w_next        = r_state;
    stall_o       = 1'b0;
    dataWord_o    = '0;
    dataValid_o   = 1'b0;
    memReqValid_o = 1'b0;
    memAddr_o     = '0;
    refillEn_o    = 1'b0;
    refillAddr_o  = '0;
    refillData_o  = '0;
    timeout_o     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (reqValid_i) begin
          if (hit_i) begin
            dataWord_o  = cacheData_i;
            dataValid_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            w_next  = REQ;
          end
        end
      end
      REQ: begin
        stall_o       = 1'b1;
        memReqValid_o = 1'b1;
        memAddr_o     = r_addr;
        if (memReqReady_i) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        // A response wins over a simultaneous timeout.
        if (memRespValid_i) begin
          w_next = REFILL;
        end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_o = 1'b1;
          w_next    = REQ;
        end
      end
      REFILL: begin
        refillEn_o   = 1'b1;
        refillAddr_o = r_addr;
        refillData_o = r_data;
        dataWord_o   = r_data;
        dataValid_o  = 1'b1;
        w_next       = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    // Reset forces outputs low immediately, not at the next edge.
    if (rst) begin
      stall_o       = 1'b0;
      dataWord_o    = '0;
      dataValid_o   = 1'b0;
      memReqValid_o = 1'b0;
      memAddr_o     = '0;
      refillEn_o    = 1'b0;
      refillAddr_o  = '0;
      refillData_o  = '0;
      timeout_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// ----------------------------------------------------------------------------
// tb_cache_miss_handler
// Self-checking bench: randomized hit/miss traffic against a word-addressed
// memory model; expected CPU data and refill writes are queued at issue time
// and popped by a monitor whenever the DUT presents them.
// ----------------------------------------------------------------------------
module tb_cache_miss_handler;

  localparam int TO      = 16;
  localparam int CNT_W   = 16;
  localparam int S_CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic [31:0] addressWord;
  logic        hit;
  logic [31:0] cacheData;
  logic        stall;
  logic [31:0] dataWord;
  logic        dataValid;
  logic        memReqValid;
  logic        memReqReady;
  logic [31:0] memAddr;
  logic        memRespValid;
  logic [31:0] memData;
  logic        refillEn;
  logic [31:0] refillAddr;
  logic [31:0] refillData;
  logic        timeout;
  logic [CNT_W-1:0] missCount;

  // Second instance with a narrow counter for saturation
  logic        s_reqValid;
  logic        s_memResp;
  logic        s_stall;
  logic [31:0] s_dataWord;
  logic        s_dataValid;
  logic        s_memReqValid;
  logic [31:0] s_memAddr;
  logic        s_refillEn;
  logic [31:0] s_refillAddr;
  logic [31:0] s_refillData;
  logic        s_timeout;
  logic [S_CNT_W-1:0] s_missCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data_q[$];
  logic [63:0] exp_refill_q[$];
  logic [31:0] mem[int unsigned];
  int          miss_model;

  always #5 clk = ~clk;

  cache_miss_handler #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .reqValid_i(reqValid), .addressWord_i(addressWord),
    .hit_i(hit), .cacheData_i(cacheData), .stall_o(stall), .dataWord_o(dataWord),
    .dataValid_o(dataValid), .memReqValid_o(memReqValid), .memReqReady_i(memReqReady),
    .memAddr_o(memAddr), .memRespValid_i(memRespValid), .memData_i(memData),
    .refillEn_o(refillEn), .refillAddr_o(refillAddr), .refillData_o(refillData),
    .timeout_o(timeout), .missCount_o(missCount)
  );

  cache_miss_handler #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(S_CNT_W)
  ) u_sat (
    .clk(clk), .rst(rst), .reqValid_i(s_reqValid), .addressWord_i(32'h40),
    .hit_i(1'b0), .cacheData_i(32'h0), .stall_o(s_stall), .dataWord_o(s_dataWord),
    .dataValid_o(s_dataValid), .memReqValid_o(s_memReqValid), .memReqReady_i(1'b1),
    .memAddr_o(s_memAddr), .memRespValid_i(s_memResp), .memData_i(32'hA5A5_0000),
    .refillEn_o(s_refillEn), .refillAddr_o(s_refillAddr), .refillData_o(s_refillData),
    .timeout_o(s_timeout), .missCount_o(s_missCount)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_cnt(input int n, input int w);
    int maxv;
    maxv = (1 << w) - 1;
    return (n > maxv) ? 64'(maxv) : 64'(n);
  endfunction

  task automatic get_mem(input logic [31:0] wa, output logic [31:0] d);
    if (!mem.exists(wa >> 2)) mem[wa >> 2] = $urandom;
    d = mem[wa >> 2];
  endtask

  // Monitor: every data return and refill write must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (dataValid) begin
        if (exp_data_q.size() == 0) chk("unexpected_dataValid", 1, 0);
        else chk("cpu_data", dataWord, exp_data_q.pop_front());
      end
      if (refillEn) begin
        if (exp_refill_q.size() == 0) chk("unexpected_refill", 1, 0);
        else chk("refill_addr_data", {refillAddr, refillData}, exp_refill_q.pop_front());
      end
    end
  end

  task automatic do_hit(input logic [31:0] d);
    reqValid    = 1'b1;
    hit         = 1'b1;
    cacheData   = d;
    addressWord = $urandom;
    exp_data_q.push_back(d);
    @(negedge clk);
    chk("hit_stall", stall, 0);
    chk("hit_memreq", memReqValid, 0);
    tick();
    reqValid = 1'b0;
  endtask

  // One complete miss: bp cycles of backpressure, response rd cycles after
  // acceptance, optionally one timeout and reissue before the response.
  task automatic do_miss(input logic [31:0] a, input int bp, input int rd, input bit with_to);
    logic [31:0] wa;
    logic [31:0] d;
    wa = {a[31:2], 2'b00};
    get_mem(wa, d);
    reqValid    = 1'b1;
    hit         = 1'b0;
    addressWord = a;
    cacheData   = $urandom;
    miss_model++;
    exp_data_q.push_back(d);
    exp_refill_q.push_back({wa, d});
    @(negedge clk);
    chk("miss_stall", stall, 1);
    chk("miss_memreq_idle", memReqValid, 0);
    tick();
    for (int j = 0; j <= bp; j++) begin
      // Inputs below are outside IDLE/WAIT and must be ignored.
      reqValid     = 1'($urandom);
      hit          = 1'($urandom);
      addressWord  = $urandom;
      memReqReady  = (j == bp);
      memRespValid = (j < bp) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (j == 0) chk("miss_count", 64'(missCount), exp_cnt(miss_model, CNT_W));
      chk("req_valid", memReqValid, 1);
      chk("req_addr", memAddr, wa);
      chk("req_stall", stall, 1);
      tick();
    end
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    if (with_to) begin
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk);
        chk("wait_timeout", timeout, (k == TO));
        chk("wait_noreq", memReqValid, 0);
        tick();
      end
      memReqReady = 1'b1;
      @(negedge clk);
      chk("reissue_valid", memReqValid, 1);
      chk("reissue_addr", memAddr, wa);
      chk("reissue_timeout_low", timeout, 0);
      tick();
      memReqReady = 1'b0;
    end
    for (int j = 1; j < rd; j++) begin
      @(negedge clk);
      chk("wait_stall", stall, 1);
      chk("wait_noreq", memReqValid, 0);
      tick();
    end
    memRespValid = 1'b1;
    memData      = d;
    @(negedge clk);
    chk("resp_stall", stall, 1);
    tick();
    memRespValid = 1'b0;
    memData      = $urandom;
    reqValid     = 1'b0;
    @(negedge clk);
    chk("refill_stall", stall, 0);
    chk("refill_en", refillEn, 1);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_memreq"}, memReqValid, 0);
    chk({tag, "_outs"}, {dataValid, refillEn, timeout, memAddr, refillAddr}, 0);
    chk({tag, "_data"}, {dataWord, refillData}, 0);
    chk({tag, "_count"}, 64'(missCount), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    reqValid     = 1'b0;
    hit          = 1'b0;
    addressWord  = '0;
    cacheData    = '0;
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    memData      = '0;
    s_reqValid   = 1'b0;
    s_memResp    = 1'b0;
    miss_model   = 0;
    mem[32'h1004 >> 2] = 32'h1234_5678;

    tick();
    #1;
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    do_hit(32'hDEAD_BEEF);
    do_miss(32'h0000_1007, 0, 2, 1'b0);
    do_miss(32'h0000_2002, 0, 1, 1'b0);
    do_miss(32'h0000_3ABC, 5, 1, 1'b0);
    do_miss(32'h0000_4001, 0, 3, 1'b1);
    do_hit(32'h0BAD_F00D);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(1, 0) == 1) do_hit($urandom);
      else do_miss($urandom, $urandom_range(4, 0), $urandom_range(6, 1), 1'b0);
    end

    // Reset while waiting for a response
    reqValid    = 1'b1;
    hit         = 1'b0;
    addressWord = 32'h0000_5555;
    tick();
    reqValid    = 1'b0;
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    tick();
    #2;
    chk("midwait_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst        = 1'b0;
    miss_model = 0;
    tick();
    memRespValid = 1'b1;
    memData      = 32'hFFFF_0000;
    @(negedge clk);
    chk("late_resp_refill", refillEn, 0);
    chk("late_resp_stall", stall, 0);
    tick();
    memRespValid = 1'b0;
    @(negedge clk);
    chk("late_resp_after", {refillEn, dataValid}, 0);
    tick();
    do_hit(32'hCAFE_0001);
    do_miss(32'h0000_6004, 1, 1, 1'b0);

    // Saturation on the narrow-counter instance
    for (int n = 1; n <= 17; n++) begin
      s_reqValid = 1'b1;
      tick();
      s_reqValid = 1'b0;
      @(negedge clk);
      chk("sat_count", 64'(s_missCount), exp_cnt(n, S_CNT_W));
      tick();
      s_memResp = 1'b1;
      tick();
      s_memResp = 1'b0;
      @(negedge clk);
      chk("sat_refill", {s_refillEn, s_refillAddr}, {1'b1, 32'h40});
      tick();
    end

    tick();
    chk("data_queue_drained", 64'(exp_data_q.size()), 0);
    chk("refill_queue_drained", 64'(exp_refill_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
- Miss/refill controller directly downstream of two_way_associative_cache.
- On a cache hit, passes the cache data straight through to the CPU.
- On a miss, stalls the CPU, fetches the word from main memory over a valid/ready request plus a response-valid return, and drives a one-cycle refill write into the cache.
- The fetched word is returned to the CPU in that same refill cycle.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT_CYCLES, 255, WAIT cycles with no response before the request is reissued.
- CNT_WIDTH, 16, width of the saturating miss counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- reqValid_i  in  1  CPU load access valid this cycle.
- addressWord_i  in  ADDR_WIDTH  CPU byte address; same address that drives the cache.
- hit_i  in  1  cache hit_o.
- cacheData_i  in  DATA_WIDTH  cache dataWord_o.
- stall_o  out  1  freeze CPU pipeline.
- dataWord_o  out  DATA_WIDTH  load data to CPU.
- dataValid_o  out  1  dataWord_o valid this cycle.
- memReqValid_o  out  1  memory read request valid.
- memReqReady_i  in  1  memory accepts request.
- memAddr_o  out  ADDR_WIDTH  word-aligned request address.
- memRespValid_i  in  1  memory response valid.
- memData_i  in  DATA_WIDTH  memory response data.
- refillEn_o  out  1  cache line write enable.
- refillAddr_o  out  ADDR_WIDTH  refill address.
- refillData_o  out  DATA_WIDTH  refill data.
- timeout_o  out  1  one-cycle pulse when a request is reissued.
- missCount_o  out  CNT_WIDTH  total misses, saturating.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; latched address, latched data, timeout counter and missCount_o all cleared.
- A reset asserted mid-miss aborts the miss; memReqValid_o and stall_o fall without waiting for a clock edge.
- States: IDLE, REQ, WAIT, REFILL.
- IDLE, reqValid_i=1 and hit_i=1:
  - dataWord_o = cacheData_i and dataValid_o = 1, combinationally, zero latency.
  - stall_o = 0.
- IDLE, reqValid_i=1 and hit_i=0:
  - stall_o = 1 combinationally in the same cycle.
  - Latch {addressWord_i[ADDR_WIDTH-1:2], 2'b00}.
  - missCount_o increments, holding at all-ones once saturated.
  - Next state: REQ.
- IDLE, reqValid_i=0: no outputs asserted.
- REQ:
  - memReqValid_o = 1 and memAddr_o = latched address, both held stable until memReqReady_i = 1.
  - On handshake: next state WAIT, timeout counter cleared.
- WAIT:
  - Timeout counter increments each cycle.
  - memRespValid_i = 1: latch memData_i, next state REFILL. The response has priority if it arrives in the same cycle the counter reaches TIMEOUT_CYCLES.
  - Counter reaches TIMEOUT_CYCLES with no response: timeout_o pulses for one cycle, next state REQ (request reissued to the same address).
- REFILL, exactly one cycle:
  - refillEn_o = 1, refillAddr_o = latched address, refillData_o = latched data.
  - dataWord_o = latched data, dataValid_o = 1, stall_o = 0.
  - Next state IDLE; a new request is accepted on the following cycle.
- stall_o = 1 in REQ and WAIT, and in IDLE on a miss; 0 otherwise.
- reqValid_i, hit_i and addressWord_i are ignored outside IDLE.
- memRespValid_i is ignored outside WAIT; a spurious response has no effect.
- A response in the same cycle as the request handshake is not possible by protocol; the earliest legal response is the cycle after.
- Minimum miss latency: miss cycle, then REQ, then WAIT, then REFILL = 3 cycles after the miss cycle when ready and response each take a single cycle.

Decomposition:
- Shared package cache_pkg holds:
  - missState_t enum {IDLE, REQ, WAIT, REFILL};
  - word-offset constant BYTE_OFFSET = 2;
  - localparam widths shared with two_way_associative_cache.
- No sub-module. The timeout counter and the miss counter are inline always_ff blocks; next-state and output logic is a single always_comb.

Test Plan:
- Hit: reqValid_i=1, hit_i=1, cacheData_i=0xDEADBEEF → same cycle dataWord_o=0xDEADBEEF, dataValid_o=1, stall_o=0, memReqValid_o=0.
- Miss, ready immediately, response 2 cycles later: addr 0x0000_1007, memData_i=0x12345678 →
  - memAddr_o=0x0000_1004;
  - stall_o high until REFILL;
  - one-cycle refillEn_o with refillAddr_o=0x1004 and refillData_o=0x12345678;
  - dataValid_o=1 in that cycle;
  - missCount_o=1.
- Backpressure: memReqReady_i low for 5 cycles → memReqValid_o and memAddr_o stable for all 5; WAIT is entered only after ready goes high.
- Timeout: no response for TIMEOUT_CYCLES → one timeout_o pulse, memReqValid_o reasserted at the same address; a later response completes the refill normally.
- Reset mid-WAIT: assert rst → all outputs 0 immediately. After release, a response arriving late is ignored and a hit is served normally.
- Saturation: CNT_WIDTH=4 build, 17 misses → missCount_o holds at 15.
